// File: rtl/fifo_ctrl_pkg.sv
// Shared sizing helpers for the NTT/INTT FIFO-controller group.
// Client modules use these so their FIFO storage matches the pointers produced here.
package fifo_ctrl_pkg;

    localparam int NTT_STAGE_CNT_DEF = 8;
    localparam int MUL_STAGE_CNT_DEF = 4;

    // Width needed to index 'value' entries, never less than one bit.
    function automatic int clog2_min1(input int value);
        int bits;
        bits = 0;
        for (int b = 0; b < 31; b++) begin
            if ((1 << b) < value) begin
                bits = b + 1;
            end
        end
        return (bits < 1) ? 1 : bits;
    endfunction

    function automatic int max_hrs_of(input int nttStageCnt);
        return 1 << (nttStageCnt - 2);
    endfunction

    function automatic int aw_of(input int nttStageCnt, input int mulStageCnt);
        int largest;
        largest = max_hrs_of(nttStageCnt);
        if (mulStageCnt > largest) begin
            largest = mulStageCnt;
        end
        return clog2_min1(largest);
    endfunction

    function automatic int mw_of(input int mulStageCnt);
        return clog2_min1(mulStageCnt - 1);
    endfunction

    // Butterfly stage i delays by half the remaining span; the last stages collapse to one entry.
    function automatic int stage_depth_of(input int nttStageCnt, input int stage);
        int depth;
        depth = max_hrs_of(nttStageCnt) >> stage;
        return (depth < 1) ? 1 : depth;
    endfunction

    function automatic int fifom_depth_of(input int mulStageCnt);
        return (mulStageCnt - 1 < 1) ? 1 : mulStageCnt - 1;
    endfunction

    localparam int MAX_HRS = max_hrs_of(NTT_STAGE_CNT_DEF);
    localparam int AW      = aw_of(NTT_STAGE_CNT_DEF, MUL_STAGE_CNT_DEF);
    localparam int MW      = mw_of(MUL_STAGE_CNT_DEF);

    function automatic int stage_depth(input int stage);
        return stage_depth_of(NTT_STAGE_CNT_DEF, stage);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Wrapping modulo-DEPTH pointer with a registered wrap pulse.
// A depth of one keeps the pointer at zero and pulses wrap on every enable.
module mod_counter #(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(DEPTH - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         wrap_q;
    logic         wrap_d;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (en) begin
            wrap_d = (cnt_q == LAST);
            cnt_d  = wrap_d ? '0 : cnt_q + W'(1);
        end
    end

    // Reset and clear both win over an enable arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/fifo_addr_counter.sv
// Merges NTT/INTT client stage enables and runs one wrapping pointer per butterfly
// stage plus one for the multiplier FIFO; all outputs come straight from flops.
module fifo_addr_counter
    import fifo_ctrl_pkg::*;
#(
    parameter int NTT_STAGE_CNT = 8,
    parameter int MUL_STAGE_CNT = 4,
    parameter int NTT_CNT       = 1,
    parameter int INTT_CNT      = 1,
    localparam int FIFO2_AW     = aw_of(NTT_STAGE_CNT, MUL_STAGE_CNT),
    localparam int FIFOM_AW     = mw_of(MUL_STAGE_CNT)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clr,
    input  logic [NTT_CNT*NTT_STAGE_CNT-1:0]    ntt_en,
    input  logic [INTT_CNT*NTT_STAGE_CNT-1:0]   intt_en,
    output logic [NTT_STAGE_CNT*FIFO2_AW-1:0]   fifo2_addr,
    output logic [FIFOM_AW-1:0]                 fifom_addr,
    output logic [NTT_STAGE_CNT-1:0]            wrap
);

    logic [NTT_STAGE_CNT-1:0] stageEn;

    // NTT clients walk the stages in reverse order; coincident enables collapse into one advance.
    for (genvar s = 0; s < NTT_STAGE_CNT; s++) begin : g_merge
        logic [NTT_CNT-1:0]  fromNtt;
        logic [INTT_CNT-1:0] fromIntt;
        for (genvar j = 0; j < NTT_CNT; j++) begin : g_ntt
            assign fromNtt[j] = ntt_en[j*NTT_STAGE_CNT + (NTT_STAGE_CNT - 1 - s)];
        end
        for (genvar k = 0; k < INTT_CNT; k++) begin : g_intt
            assign fromIntt[k] = intt_en[k*NTT_STAGE_CNT + s];
        end
        assign stageEn[s] = (|fromNtt) | (|fromIntt);
    end

    for (genvar i = 0; i < NTT_STAGE_CNT; i++) begin : g_stage
        localparam int D  = stage_depth_of(NTT_STAGE_CNT, i);
        localparam int SW = clog2_min1(D);

        logic [SW-1:0] stageCnt;

        mod_counter #(
            .DEPTH (D),
            .W     (SW)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .en    (stageEn[i]),
            .cnt   (stageCnt),
            .wrap  (wrap[i])
        );

        assign fifo2_addr[i*FIFO2_AW +: FIFO2_AW] = FIFO2_AW'(stageCnt);
    end

    mod_counter #(
        .DEPTH (fifom_depth_of(MUL_STAGE_CNT)),
        .W     (FIFOM_AW)
    ) u_fifom (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (|stageEn),
        .cnt   (fifom_addr),
        .wrap  ()
    );

endmodule

// File: tb/tb_fifo_addr_counter.sv
// Self-checking bench for fifo_addr_counter: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a modulo-arithmetic model.
module tb_fifo_addr_counter;

    localparam int NSC = 8;
    localparam int MSC = 4;
    localparam int NC  = 1;
    localparam int IC  = 1;
    localparam int AW  = 6;
    localparam int MW  = 2;
    localparam int FD  = MSC - 1;
    localparam int NW  = NC * NSC;
    localparam int IW  = IC * NSC;

    logic            clk = 1'b0;
    logic            rst;
    logic            clr;
    logic [NW-1:0]   nttEn;
    logic [IW-1:0]   inttEn;
    logic [NSC*AW-1:0] fifo2Addr;
    logic [MW-1:0]   fifomAddr;
    logic [NSC-1:0]  wrap;

    int checkCount = 0;
    int errorCount = 0;
    bit compareOn  = 1'b0;

    always #5 clk = ~clk;

    fifo_addr_counter #(
        .NTT_STAGE_CNT (NSC),
        .MUL_STAGE_CNT (MSC),
        .NTT_CNT       (NC),
        .INTT_CNT      (IC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .ntt_en     (nttEn),
        .intt_en    (inttEn),
        .fifo2_addr (fifo2Addr),
        .fifom_addr (fifomAddr),
        .wrap       (wrap)
    );

    function automatic int depthOf(input int stage);
        int d;
        d = 64 >> stage;
        return (d < 1) ? 1 : d;
    endfunction

    function automatic logic [NSC-1:0] mergedEnables(input logic [NW-1:0] n, input logic [IW-1:0] t);
        logic [NSC-1:0] r;
        r = '0;
        for (int s = 0; s < NSC; s++) begin
            for (int j = 0; j < NC; j++) begin
                if (n[j*NSC + (NSC - 1 - s)]) r[s] = 1'b1;
            end
            for (int k = 0; k < IC; k++) begin
                if (t[k*NSC + s]) r[s] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] addrOf(input int stage);
        return 32'(fifo2Addr[stage*AW +: AW]);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NW-1:0] n, input logic [IW-1:0] t,
                                 input logic r, input logic c);
        nttEn  = n;
        inttEn = t;
        rst    = r;
        clr    = c;
        @(negedge clk);
    endtask

    // Reference model: each stage pointer is a count modulo its depth.
    int             mPtr [NSC];
    logic [NSC-1:0] mWrap;
    int             mFifom;
    logic [NSC-1:0] modelEnc;

    always_comb modelEnc = mergedEnables(nttEn, inttEn);

    always @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < NSC; i++) mPtr[i] <= 0;
            mWrap  <= '0;
            mFifom <= 0;
        end else begin
            for (int i = 0; i < NSC; i++) begin
                if (modelEnc[i]) begin
                    mPtr[i]  <= (mPtr[i] + 1) % depthOf(i);
                    mWrap[i] <= ((mPtr[i] + 1) % depthOf(i)) == 0;
                end else begin
                    mWrap[i] <= 1'b0;
                end
            end
            if (|modelEnc) mFifom <= (mFifom + 1) % FD;
        end
    end

    always @(negedge clk) begin
        if (compareOn) begin
            for (int i = 0; i < NSC; i++) begin
                checkOutput($sformatf("model fifo2_addr[%0d]", i), addrOf(i), 32'(mPtr[i]));
            end
            checkOutput("model wrap", 32'(wrap), 32'(mWrap));
            checkOutput("model fifom_addr", 32'(fifomAddr), 32'(mFifom));
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NW-1:0] n;
        logic [IW-1:0] t;
        nttEn  = '0;
        inttEn = '0;
        rst    = 1'b1;
        clr    = 1'b0;

        applyStimulus(NW'($urandom), IW'($urandom), 1'b1, 1'b0);
        compareOn = 1'b1;
        applyStimulus(NW'($urandom), IW'($urandom), 1'b1, 1'b0);
        checkOutput("reset fifo2_addr", 32'(fifo2Addr == '0), 32'd1);
        checkOutput("reset fifom_addr", 32'(fifomAddr), 32'd0);
        checkOutput("reset wrap", 32'(wrap), 32'd0);
        applyStimulus('0, '0, 1'b0, 1'b0);

        t = '0; t[0] = 1'b1;
        for (int k = 0; k < 64; k++) begin
            checkOutput($sformatf("stage0 addr step %0d", k), addrOf(0), 32'(k));
            if (k > 0) checkOutput("stage0 wrap low", 32'(wrap[0]), 32'd0);
            applyStimulus('0, t, 1'b0, 1'b0);
        end
        checkOutput("stage0 addr after wrap", addrOf(0), 32'd0);
        checkOutput("stage0 wrap pulse", 32'(wrap[0]), 32'd1);
        applyStimulus('0, '0, 1'b0, 1'b0);
        checkOutput("stage0 wrap single", 32'(wrap[0]), 32'd0);

        applyStimulus('0, '0, 1'b0, 1'b1);
        t = '0; t[6] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus('0, t, 1'b0, 1'b0);
            checkOutput("stage6 addr", addrOf(6), 32'd0);
            checkOutput("stage6 wrap", 32'(wrap[6]), 32'd1);
        end
        n = '0; n[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(n, '0, 1'b0, 1'b0);
            checkOutput("stage7 addr", addrOf(7), 32'd0);
            checkOutput("stage7 wrap", 32'(wrap[7]), 32'd1);
            checkOutput("stage6 wrap idle", 32'(wrap[6]), 32'd0);
        end
        applyStimulus('0, '0, 1'b0, 1'b0);
        checkOutput("stage7 wrap idle", 32'(wrap[7]), 32'd0);

        applyStimulus('0, '0, 1'b0, 1'b1);
        n = '0; n[7] = 1'b1;
        applyStimulus(n, '0, 1'b0, 1'b0);
        checkOutput("reversal stage0 advance", addrOf(0), 32'd1);
        for (int i = 1; i < NSC; i++) begin
            checkOutput($sformatf("reversal stage%0d hold", i), addrOf(i), 32'd0);
        end
        t = '0; t[0] = 1'b1;
        applyStimulus(n, t, 1'b0, 1'b0);
        checkOutput("merged single advance", addrOf(0), 32'd2);

        applyStimulus('0, '0, 1'b0, 1'b1);
        t = '0; t[3] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("fifom step %0d", k), 32'(fifomAddr), 32'(k % 3));
            applyStimulus('0, t, 1'b0, 1'b0);
        end
        checkOutput("fifom final", 32'(fifomAddr), 32'd2);

        for (int pass = 0; pass < 2; pass++) begin
            applyStimulus('0, '0, 1'b0, 1'b1);
            t = '0; t[1] = 1'b1;
            for (int k = 0; k < 17; k++) applyStimulus('0, t, 1'b0, 1'b0);
            checkOutput("stage1 at 17", addrOf(1), 32'd17);
            applyStimulus('1, '1, pass == 1, pass == 0);
            checkOutput("flush fifo2_addr", 32'(fifo2Addr == '0), 32'd1);
            checkOutput("flush fifom_addr", 32'(fifomAddr), 32'd0);
            checkOutput("flush wrap", 32'(wrap), 32'd0);
            applyStimulus('0, t, 1'b0, 1'b0);
            checkOutput("stage1 restart", addrOf(1), 32'd1);
        end

        for (int cyc = 0; cyc < 3000; cyc++) begin
            applyStimulus(NW'($urandom), IW'($urandom),
                          $urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0);
        end
        applyStimulus('0, '0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
